cmi_multi_timeslot_generator: RTL and testbench
===============================================

// Module: cmi_multi_timeslot_generator
// PURPOSE
//  Multi-channel CMI timeslot marker generator. Each channel emits one-clock
//  markers spaced PERIOD+1 clocks apart, in one of two modes:
//  - burst: exactly COUNT markers, then a done pulse.
//  - continuous: markers until stopped.
//  Sits between the CMI framing control and the per-lane timeslot consumers.
//  Per-channel config, start/stop and remaining-count readback.
// PARAMETERS
//  CHANNELS  4   number of independent channels (1..16)
//  PERIOD_W  16  width of period field; marker spacing = period+1 clocks
//  COUNT_W   24  width of burst marker count
//  CH_W      2   channel select width, >= clog2(CHANNELS)
// PORTS
//  clk           in   1           system clock, all logic on rising edge
//  rst_n         in   1           asynchronous reset, active low
//  cfg_we        in   1           config write strobe
//  cfg_ch        in   CH_W        channel addressed by cfg_we / rd
//  cfg_period    in   PERIOD_W    period to store
//  cfg_count     in   COUNT_W     burst marker count to store
//  cfg_mode      in   1           0 = burst, 1 = continuous
//  start         in   CHANNELS    per-channel start/restart pulse
//  stop          in   CHANNELS    per-channel abort pulse
//  marker        out  CHANNELS    registered one-clock timeslot marker
//  busy          out  CHANNELS    channel in RUN
//  done          out  CHANNELS    one-clock pulse on burst completion
//  rd_remaining  out  COUNT_W     remaining burst markers of channel cfg_ch (comb mux)
// BEHAVIOUR
//  Reset
//  - rst_n low clears all config, counters and state: every channel IDLE.
//  - marker = busy = done = 0 while rst_n is low.
//  - rst_n low mid-run aborts immediately; no done pulse.
//  Config
//  - On cfg_we, {period, count, mode} are stored in channel cfg_ch's config registers.
//  - cfg_ch >= CHANNELS: write ignored.
//  - Writes to a running channel do not disturb the active run; they are used at the next start.
//  Per-channel state: IDLE, RUN. busy = (state == RUN).
//  Start, sampled at edge E0
//  - Copies config into active regs: phase <= period, remaining <= count.
//  - Then goes to RUN.
//  - Burst with count = 0: stays IDLE, done = 1 for the cycle after E0, no marker, busy stays 0.
//  RUN, each edge
//  - phase != 0: phase <= phase - 1, marker <= 0.
//  - phase == 0: marker <= 1, phase <= active period.
//  - Burst only, on phase == 0: remaining <= remaining - 1.
//    If remaining == 1: done <= 1, state <= IDLE (done and last marker coincide; busy drops same cycle).
//  - Continuous: remaining is held and never decremented; done is never asserted.
//  Timing
//  - First marker is high in the cycle after edge E0 + period + 1.
//  - Subsequent markers every period + 1 clocks.
//  - period = 0 gives a marker every clock.
//  - No wrap: remaining never decrements below 1 in RUN.
//  Priorities, per channel, same edge
//  - stop > start > normal counting.
//  - stop in RUN: IDLE next edge, marker = 0, no done. stop in IDLE: no effect.
//  - start in RUN: restart from fresh config; no done for the aborted run.
//  - cfg_we and start on the same channel and edge: start uses the OLD stored config.
//  Channels are fully independent; simultaneous starts/stops on many channels are legal.
// TESTING
//  1. ch0 burst, period=3, count=4, start at E0
//     -> markers in the cycles after E4, E8, E12, E16; done with the E16 marker;
//        busy high E0..E16 (falls with done).
//  2. ch1 continuous, period=0, start, stop after 10 clocks
//     -> marker every clock from E1; marker and busy low the cycle after stop; no done.
//  3. ch2 burst, count=0, start
//     -> done = 1 for one cycle, busy and marker never high.
//  4. ch3 burst, period=5, count=3; restart after 1st marker; cfg_we period=2 mid-run
//     -> run restarts with period=5 (old config) and 3 more markers, no done from the aborted run;
//        the next start uses period=2.
//  5. All channels running, different periods; rst_n low 1 clock mid-run
//     -> all outputs 0 asynchronously, all channels IDLE, rd_remaining = 0.
//  6. cfg_we with cfg_ch=5 and CHANNELS=4 -> no config change; rd_remaining for ch1 during burst
//     count=7 reads 7,6,5,... after each marker.

Source files
------------

// File: rtl/cmi_multi_timeslot_generator.sv
// cmi_multi_timeslot_generator
//   Multi-channel CMI timeslot marker generator. Each channel emits one-clock
//   markers spaced period+1 clocks apart, either as a burst of a configured
//   count (ending in a done pulse) or continuously until stopped.
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   cfg_we/cfg_ch      config write strobe and channel select (also read select)
//   cfg_period/count   period and burst count stored on cfg_we
//   cfg_mode           0 = burst, 1 = continuous
//   start/stop         per-channel start/restart and abort pulses
//   marker             registered one-clock timeslot marker per channel
//   busy               channel is running
//   done               one-clock pulse on burst completion
//   rd_remaining       remaining burst markers of channel cfg_ch
module cmi_multi_timeslot_generator #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned PERIOD_W = 16,
   parameter int unsigned COUNT_W  = 24,
   parameter int unsigned CH_W     = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [COUNT_W-1:0]  cfg_count,
   input  logic                cfg_mode,
   input  logic [CHANNELS-1:0] start,
   input  logic [CHANNELS-1:0] stop,
   output logic [CHANNELS-1:0] marker,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] done,
   output logic [COUNT_W-1:0]  rd_remaining
);

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e              state_q      [CHANNELS];
   logic [PERIOD_W-1:0] cfg_period_q [CHANNELS];
   logic [COUNT_W-1:0]  cfg_count_q  [CHANNELS];
   logic                cfg_mode_q   [CHANNELS];
   logic [PERIOD_W-1:0] act_period_q [CHANNELS];
   logic                act_mode_q   [CHANNELS];
   logic [PERIOD_W-1:0] phase_q      [CHANNELS];
   logic [COUNT_W-1:0]  remaining_q  [CHANNELS];
   logic [CHANNELS-1:0] marker_q;
   logic [CHANNELS-1:0] done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         marker_q <= '0;
         done_q   <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_q[i]      <= ST_IDLE;
            cfg_period_q[i] <= '0;
            cfg_count_q[i]  <= '0;
            cfg_mode_q[i]   <= 1'b0;
            act_period_q[i] <= '0;
            act_mode_q[i]   <= 1'b0;
            phase_q[i]      <= '0;
            remaining_q[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            // Selects beyond CHANNELS never match, so such writes are dropped.
            if (cfg_we && (32'(cfg_ch) == i)) begin
               cfg_period_q[i] <= cfg_period;
               cfg_count_q[i]  <= cfg_count;
               cfg_mode_q[i]   <= cfg_mode;
            end

            marker_q[i] <= 1'b0;
            done_q[i]   <= 1'b0;

            if (stop[i]) begin
               state_q[i] <= ST_IDLE;
            end else if (start[i]) begin
               // Reads the stored config before any same-edge write lands.
               act_period_q[i] <= cfg_period_q[i];
               act_mode_q[i]   <= cfg_mode_q[i];
               phase_q[i]      <= cfg_period_q[i];
               remaining_q[i]  <= cfg_count_q[i];
               if (!cfg_mode_q[i] && (cfg_count_q[i] == '0)) begin
                  state_q[i] <= ST_IDLE;
                  done_q[i]  <= 1'b1;
               end else begin
                  state_q[i] <= ST_RUN;
               end
            end else if (state_q[i] == ST_RUN) begin
               if (phase_q[i] != '0) begin
                  phase_q[i] <= phase_q[i] - 1'b1;
               end else begin
                  marker_q[i] <= 1'b1;
                  phase_q[i]  <= act_period_q[i];
                  if (!act_mode_q[i]) begin
                     remaining_q[i] <= remaining_q[i] - 1'b1;
                     if (remaining_q[i] == COUNT_W'(1)) begin
                        done_q[i]  <= 1'b1;
                        state_q[i] <= ST_IDLE;
                     end
                  end
               end
            end
         end
      end
   end

   always_comb begin
      busy         = '0;
      rd_remaining = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         busy[i] = (state_q[i] == ST_RUN);
         if (32'(cfg_ch) == i) rd_remaining = remaining_q[i];
      end
   end

   assign marker = marker_q;
   assign done   = done_q;

endmodule

// File: tb/tb_cmi_multi_timeslot_generator.sv
module tb_cmi_multi_timeslot_generator;
   localparam int unsigned CH  = 4;
   localparam int unsigned PW  = 16;
   localparam int unsigned CW  = 24;
   localparam int unsigned CHW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_we;
   logic [CHW-1:0] cfg_ch;
   logic [PW-1:0] cfg_period;
   logic [CW-1:0] cfg_count;
   logic          cfg_mode;
   logic [CH-1:0] start;
   logic [CH-1:0] stop;
   logic [CH-1:0] marker;
   logic [CH-1:0] busy;
   logic [CH-1:0] done;
   logic [CW-1:0] rd_remaining;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cmi_multi_timeslot_generator #(
      .CHANNELS(CH), .PERIOD_W(PW), .COUNT_W(CW), .CH_W(CHW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_period(cfg_period), .cfg_count(cfg_count), .cfg_mode(cfg_mode),
      .start(start), .stop(stop), .marker(marker), .busy(busy), .done(done),
      .rd_remaining(rd_remaining)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int ch, input int period, input int count, input logic mode);
      cfg_we     = 1'b1;
      cfg_ch     = CHW'(ch);
      cfg_period = PW'(period);
      cfg_count  = CW'(count);
      cfg_mode   = mode;
      tick();
      cfg_we     = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_count = '0;
      cfg_mode = 1'b0; start = '0; stop = '0;
      #2;
      chk("rst_marker", 32'(marker), 32'h0);
      chk("rst_busy",   32'(busy),   32'h0);
      chk("rst_done",   32'(done),   32'h0);
      chk("rst_rdrem",  32'(rd_remaining), 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // 1: ch0 burst period 3 count 4
      cfg(0, 3, 4, 1'b0);
      cfg_ch = 3'd0;
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      chk("t1_busy0", 32'(busy[0]), 32'h1);
      chk("t1_rd0",   32'(rd_remaining), 32'd4);
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("t1_marker_e%0d", k), 32'(marker[0]), 32'((k % 4) == 0));
         chk($sformatf("t1_busy_e%0d", k),   32'(busy[0]),   32'(k < 16));
         chk($sformatf("t1_done_e%0d", k),   32'(done[0]),   32'(k == 16));
         chk($sformatf("t1_rd_e%0d", k),     32'(rd_remaining), 32'(4 - k / 4));
      end
      tick();
      chk("t1_done_after", 32'(done[0]), 32'h0);

      // 2: ch1 continuous period 0, stopped after 10 clocks
      cfg(1, 0, 9, 1'b1);
      start[1] = 1'b1; tick(); start[1] = 1'b0;
      chk("t2_busy", 32'(busy[1]), 32'h1);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("t2_marker_e%0d", k), 32'(marker[1]), 32'h1);
         chk($sformatf("t2_done_e%0d", k),   32'(done[1]),   32'h0);
      end
      stop[1] = 1'b1; tick(); stop[1] = 1'b0;
      chk("t2_marker_stop", 32'(marker[1]), 32'h0);
      chk("t2_busy_stop",   32'(busy[1]),   32'h0);
      chk("t2_done_stop",   32'(done[1]),   32'h0);
      tick();
      chk("t2_done_after",  32'(done[1]),   32'h0);

      // 3: ch2 burst count 0
      cfg(2, 4, 0, 1'b0);
      start[2] = 1'b1; tick(); start[2] = 1'b0;
      chk("t3_done",   32'(done[2]),   32'h1);
      chk("t3_busy",   32'(busy[2]),   32'h0);
      chk("t3_marker", 32'(marker[2]), 32'h0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("t3_done_e%0d", k),   32'(done[2]),   32'h0);
         chk($sformatf("t3_busy_e%0d", k),   32'(busy[2]),   32'h0);
         chk($sformatf("t3_marker_e%0d", k), 32'(marker[2]), 32'h0);
      end

      // 4: ch3 restart after first marker with same-edge config write
      cfg(3, 5, 3, 1'b0);
      start[3] = 1'b1; tick(); start[3] = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("t4a_marker_e%0d", k), 32'(marker[3]), 32'(k == 6));
      end
      cfg_we = 1'b1; cfg_ch = 3'd3; cfg_period = 16'd2; cfg_count = 24'd3; cfg_mode = 1'b0;
      start[3] = 1'b1; tick(); start[3] = 1'b0; cfg_we = 1'b0;
      chk("t4_restart_done", 32'(done[3]), 32'h0);
      chk("t4_restart_busy", 32'(busy[3]), 32'h1);
      for (int k = 1; k <= 18; k++) begin
         tick();
         chk($sformatf("t4b_marker_e%0d", k), 32'(marker[3]), 32'((k % 6) == 0));
         chk($sformatf("t4b_done_e%0d", k),   32'(done[3]),   32'(k == 18));
         chk($sformatf("t4b_busy_e%0d", k),   32'(busy[3]),   32'(k < 18));
      end
      start[3] = 1'b1; tick(); start[3] = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk($sformatf("t4c_marker_e%0d", k), 32'(marker[3]), 32'((k % 3) == 0));
         chk($sformatf("t4c_done_e%0d", k),   32'(done[3]),   32'(k == 9));
      end

      // 5: all channels running, reset mid-run
      cfg(0, 1, 100, 1'b0);
      cfg(1, 2, 7, 1'b1);
      cfg(2, 3, 50, 1'b0);
      cfg(3, 4, 5, 1'b1);
      cfg_ch = 3'd0;
      start = 4'hF; tick(); start = '0;
      for (int k = 1; k <= 7; k++) tick();
      chk("t5_busy_pre", 32'(busy), 32'hF);
      chk("t5_rd_pre",   32'(rd_remaining), 32'd97);
      rst_n = 1'b0;
      #1;
      chk("t5_marker_rst", 32'(marker), 32'h0);
      chk("t5_busy_rst",   32'(busy),   32'h0);
      chk("t5_done_rst",   32'(done),   32'h0);
      chk("t5_rd_rst",     32'(rd_remaining), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t5_busy_post", 32'(busy),   32'h0);
      chk("t5_done_post", 32'(done),   32'h0);
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      chk("t5_cfg_cleared_done", 32'(done[0]), 32'h1);
      chk("t5_cfg_cleared_busy", 32'(busy[0]), 32'h0);

      // 6: out-of-range write ignored; ch1 readback during burst
      cfg(1, 1, 7, 1'b0);
      cfg(5, 9, 99, 1'b1);
      cfg_ch = 3'd1;
      start[1] = 1'b1; tick(); start[1] = 1'b0;
      chk("t6_rd_e0", 32'(rd_remaining), 32'd7);
      for (int k = 1; k <= 14; k++) begin
         tick();
         chk($sformatf("t6_rd_e%0d", k),     32'(rd_remaining), 32'(7 - k / 2));
         chk($sformatf("t6_marker_e%0d", k), 32'(marker[1]),    32'((k % 2) == 0));
         chk($sformatf("t6_done_e%0d", k),   32'(done[1]),      32'(k == 14));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
